uart_tx_fifo_reader: RTL and testbench

- UART transmit engine on the read side of the TX byte FIFO.
- Pops one word at a time from the FIFO, then serializes it onto the line: start bit, data LSB first, optional parity, stop bit(s).
- Sits between the TX fifo instance and the o_tx pad; host logic only writes the FIFO.

---
 rtl/uart_tx_fifo_reader.sv | 205 ++++++++++++++++++++
 tb/tb_uart_tx_fifo_reader.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_reader.sv
// ----------------------------------------------------------------------------
// uart_tx_fifo_reader
//
// UART transmit engine on the read side of the TX byte FIFO. Pops one word,
// then serializes it: start bit, data LSB first, optional parity, stop bit(s).
//
// Ports:
//   i_clk           system clock
//   i_rst_n         asynchronous active-low reset (aborts any frame in flight)
//   i_enable        permits starting new frames (sampled only in IDLE)
//   i_fifo_data     FIFO read data, valid the cycle after o_fifo_read_en
//   i_fifo_empty    FIFO empty flag
//   o_fifo_read_en  one-cycle FIFO pop strobe (high only in FETCH)
//   o_tx            serial line, idle high, registered
//   o_busy          high whenever the FSM is not in IDLE
//   o_done          one-cycle pulse in the first IDLE cycle after a frame
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | line high, waiting for enable and a non-empty FIFO
// FETCH  | pop strobe to the FIFO
// LOAD   | FIFO data valid; capture word and parity, drive start level
// START  | start bit on the line
// DATA   | data bits, LSB first
// PARITY | parity bit (only reached when ParityEn != 0)
// STOP   | stop bit(s)
// ----------------------------------------------------------------------------
module uart_tx_fifo_reader #(
    parameter int DataWidth  = 8,
    parameter int ClksPerBit = 434,
    parameter int ParityEn   = 0,
    parameter int ParityOdd  = 0,
    parameter int StopBits   = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_enable,
    input  logic [DataWidth-1:0] i_fifo_data,
    input  logic                 i_fifo_empty,
    output logic                 o_fifo_read_en,
    output logic                 o_tx,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam int BaudW = $clog2(ClksPerBit);
    localparam int BitW  = (DataWidth > 1) ? $clog2(DataWidth) : 1;

    localparam logic [BaudW-1:0] BaudLast   = BaudW'(ClksPerBit - 1);
    localparam logic [BitW-1:0]  BitLast    = BitW'(DataWidth - 1);
    localparam logic             StopLast   = (StopBits > 1);
    localparam logic             ParityInit = (ParityOdd != 0);
    localparam logic             HasParity  = (ParityEn != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [BaudW-1:0]     baud_cnt;
    logic [BitW-1:0]      bit_cnt;
    logic                 stop_cnt;
    logic [DataWidth-1:0] shift_reg;
    logic [DataWidth-1:0] shift_next;
    logic                 parity_bit;
    logic                 tx_reg;
    logic                 done_reg;
    logic                 baud_tc;
    logic                 counting;

    always_comb begin
        state_next     = state;
        baud_tc        = (baud_cnt == BaudLast);
        counting       = 1'b0;
        shift_next     = shift_reg >> 1;
        o_fifo_read_en = 1'b0;
        o_busy         = (state != S_IDLE);

        case (state)
            S_IDLE: begin
                if (i_enable && !i_fifo_empty) begin
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                o_fifo_read_en = 1'b1;
                state_next     = S_LOAD;
            end
            S_LOAD: begin
                state_next = S_START;
            end
            S_START: begin
                counting = 1'b1;
                if (baud_tc) begin
                    state_next = S_DATA;
                end
            end
            S_DATA: begin
                counting = 1'b1;
                if (baud_tc && (bit_cnt == BitLast)) begin
                    state_next = HasParity ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                counting = 1'b1;
                if (baud_tc) begin
                    state_next = S_STOP;
                end
            end
            S_STOP: begin
                counting = 1'b1;
                if (baud_tc && (stop_cnt == StopLast)) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath: o_tx changes on the same edge as the state transition, so each
    // line level lasts exactly ClksPerBit cycles.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            tx_reg     <= 1'b1;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;

            if (counting && !baud_tc) begin
                baud_cnt <= baud_cnt + BaudW'(1);
            end else begin
                baud_cnt <= '0;
            end

            case (state)
                S_LOAD: begin
                    shift_reg  <= i_fifo_data;
                    parity_bit <= (^i_fifo_data) ^ ParityInit;
                    tx_reg     <= 1'b0;
                    bit_cnt    <= '0;
                    stop_cnt   <= 1'b0;
                end
                S_START: begin
                    if (baud_tc) begin
                        tx_reg <= shift_reg[0];
                    end
                end
                S_DATA: begin
                    if (baud_tc) begin
                        if (bit_cnt == BitLast) begin
                            tx_reg <= HasParity ? parity_bit : 1'b1;
                        end else begin
                            bit_cnt   <= bit_cnt + BitW'(1);
                            shift_reg <= shift_next;
                            tx_reg    <= shift_next[0];
                        end
                    end
                end
                S_PARITY: begin
                    if (baud_tc) begin
                        tx_reg <= 1'b1;
                    end
                end
                S_STOP: begin
                    if (baud_tc) begin
                        if (stop_cnt == StopLast) begin
                            done_reg <= 1'b1;
                        end else begin
                            stop_cnt <= 1'b1;
                        end
                    end
                end
                default: begin
                    tx_reg <= 1'b1;
                end
            endcase
        end
    end

    assign o_tx   = tx_reg;
    assign o_done = done_reg;

endmodule

// File: tb/tb_uart_tx_fifo_reader.sv
// ----------------------------------------------------------------------------
// Testbench for uart_tx_fifo_reader. Three instances with ClksPerBit=4:
//   u0: no parity, 1 stop bit
//   u1: even parity, 2 stop bits
//   u2: odd parity, 2 stop bits
// Each has a small FIFO model that pops on the falling edge after the pop
// strobe, so data is stable for the whole LOAD cycle.
// ----------------------------------------------------------------------------
module tb_uart_tx_fifo_reader;

    localparam int Cpb = 4;

    logic       clk;
    logic       rst_n;
    logic [2:0] en;
    logic [2:0] empty;
    logic [2:0] rd_en;
    logic [2:0] tx;
    logic [2:0] busy;
    logic [2:0] done;
    logic [7:0] fdata [3];

    logic [7:0] mem [3][16];
    logic [3:0] wp [3];
    logic [3:0] rp [3] = '{4'd0, 4'd0, 4'd0};

    logic [255:0] hist [3];
    int rd_cnt [3];
    int busy_cnt [3];
    int done_cnt [3];
    int done_pos [3];

    int n_assert = 0;
    int n_fail   = 0;

    uart_tx_fifo_reader #(.DataWidth(8), .ClksPerBit(Cpb), .ParityEn(0), .ParityOdd(0), .StopBits(1)) u0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(en[0]), .i_fifo_data(fdata[0]),
        .i_fifo_empty(empty[0]), .o_fifo_read_en(rd_en[0]), .o_tx(tx[0]),
        .o_busy(busy[0]), .o_done(done[0]));

    uart_tx_fifo_reader #(.DataWidth(8), .ClksPerBit(Cpb), .ParityEn(1), .ParityOdd(0), .StopBits(2)) u1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(en[1]), .i_fifo_data(fdata[1]),
        .i_fifo_empty(empty[1]), .o_fifo_read_en(rd_en[1]), .o_tx(tx[1]),
        .o_busy(busy[1]), .o_done(done[1]));

    uart_tx_fifo_reader #(.DataWidth(8), .ClksPerBit(Cpb), .ParityEn(1), .ParityOdd(1), .StopBits(2)) u2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(en[2]), .i_fifo_data(fdata[2]),
        .i_fifo_empty(empty[2]), .o_fifo_read_en(rd_en[2]), .o_tx(tx[2]),
        .o_busy(busy[2]), .o_done(done[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        empty = '0;
        for (int k = 0; k < 3; k++) begin
            empty[k] = (wp[k] == rp[k]);
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rd_en[k]) begin
                fdata[k] <= mem[k][rp[k]];
                rp[k]    <= rp[k] + 4'd1;
            end
        end
    end

    task automatic push(input int k, input logic [7:0] d);
        mem[k][wp[k]] = d;
        wp[k] = wp[k] + 4'd1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Step n cycles, sampling 1 time unit after each rising edge.
    task automatic watch(input int n);
        for (int k = 0; k < 3; k++) begin
            hist[k] = '1;
            rd_cnt[k] = 0;
            busy_cnt[k] = 0;
            done_cnt[k] = 0;
            done_pos[k] = -1;
        end
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 3; k++) begin
                hist[k][c] = tx[k];
                if (rd_en[k]) rd_cnt[k]++;
                if (busy[k]) busy_cnt[k]++;
                if (done[k]) begin
                    if (done_pos[k] < 0) done_pos[k] = c;
                    done_cnt[k]++;
                end
            end
        end
    endtask

    // Expected per-cycle line levels of one frame starting at cycle pos.
    function automatic logic [255:0] put_frame(input logic [255:0] v, input int pos,
                                               input logic [7:0] d, input int pe,
                                               input int po, input int sb);
        logic [11:0] bits;
        int nb;
        logic [255:0] r;
        r = v;
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1 + i] = d[i];
        nb = 9;
        if (pe != 0) begin
            bits[nb] = (^d) ^ (po != 0);
            nb++;
        end
        nb = nb + sb;
        for (int b = 0; b < nb; b++) begin
            for (int c = 0; c < Cpb; c++) r[pos + b * Cpb + c] = bits[b];
        end
        return r;
    endfunction

    logic [255:0] e;
    logic [9:0]   sampled;

    initial begin
        en = 3'b000;
        for (int k = 0; k < 3; k++) wp[k] = 4'd0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("reset_outputs", {tx, busy, rd_en, done}, {3'b111, 3'b000, 3'b000, 3'b000});
        #20 rst_n = 1'b1;
        en = 3'b110;
        @(posedge clk);
        #1;

        // Single frame 0xA5
        push(0, 8'hA5);
        en[0] = 1'b1;
        watch(60);
        e = put_frame('1, 2, 8'hA5, 0, 0, 1);
        check("t1_line", hist[0], e);
        for (int i = 0; i < 10; i++) sampled[i] = hist[0][2 + i * Cpb + 1];
        check("t1_bits", 256'(sampled), 256'(10'b1101001010));
        check("t1_rd_pulses", rd_cnt[0], 1);
        check("t1_busy_cycles", busy_cnt[0], 42);
        check("t1_done_count", done_cnt[0], 1);
        check("t1_done_pos", done_pos[0], 42);

        // Back-to-back 0x01, 0x80, 0xFF
        push(0, 8'h01);
        push(0, 8'h80);
        push(0, 8'hFF);
        watch(140);
        e = put_frame('1, 2, 8'h01, 0, 0, 1);
        e = put_frame(e, 45, 8'h80, 0, 0, 1);
        e = put_frame(e, 88, 8'hFF, 0, 0, 1);
        check("t2_line", hist[0], e);
        check("t2_gap", 256'(hist[0][44:42]), 256'(3'b111));
        check("t2_rd_pulses", rd_cnt[0], 3);
        check("t2_done_count", done_cnt[0], 3);
        check("t2_idle_empty", {busy[0], empty[0]}, 2'b01);

        // Parity: even on u1, odd on u2, two stop bits
        push(1, 8'h07);
        push(1, 8'h03);
        push(2, 8'h07);
        push(2, 8'h03);
        watch(120);
        e = put_frame('1, 2, 8'h07, 1, 0, 2);
        e = put_frame(e, 53, 8'h03, 1, 0, 2);
        check("t3_even_line", hist[1], e);
        e = put_frame('1, 2, 8'h07, 1, 1, 2);
        e = put_frame(e, 53, 8'h03, 1, 1, 2);
        check("t3_odd_line", hist[2], e);
        check("t3_even_parity", {hist[1][39], hist[1][90]}, 2'b10);
        check("t3_odd_parity", {hist[2][39], hist[2][90]}, 2'b01);
        check("t3_stop_len", 256'(hist[1][49:42]), 256'(8'hFF));
        check("t3_done", {done_cnt[1], done_pos[1]}, {32'd2, 32'd50});

        // Empty FIFO after the last word: line stays idle, no pops
        watch(100);
        check("t6_idle_line", hist[1], '1);
        check("t6_no_pop", rd_cnt[1], 0);
        check("t6_no_done", done_cnt[1], 0);

        // Enable low with words waiting
        en[0] = 1'b0;
        push(0, 8'h3C);
        push(0, 8'hC3);
        watch(100);
        check("t4_hold_line", hist[0], '1);
        check("t4_hold_pop", rd_cnt[0], 0);
        check("t4_hold_busy", busy_cnt[0], 0);
        en[0] = 1'b1;
        watch(100);
        e = put_frame('1, 2, 8'h3C, 0, 0, 1);
        e = put_frame(e, 45, 8'hC3, 0, 0, 1);
        check("t4_release_line", hist[0], e);
        check("t4_release_pop", rd_cnt[0], 2);

        // Enable dropped mid-frame: frame completes, no further fetch
        push(0, 8'h11);
        push(0, 8'h22);
        watch(20);
        en[0] = 1'b0;
        watch(60);
        check("t4_midframe_done", done_cnt[0], 1);
        check("t4_midframe_pop", rd_cnt[0], 0);
        check("t4_midframe_busy", busy[0], 1'b0);

        // Asynchronous reset in the middle of the data bits of 0x55
        push(0, 8'h55);
        en[0] = 1'b1;
        watch(55);
        e = put_frame('1, 2, 8'h22, 0, 0, 1);
        check("t5_pre_frame", 256'(hist[0][44:0]), 256'(e[44:0]));
        check("t5_partial", 256'(hist[0][54:45]), 256'(10'b0011110000));
        #1 rst_n = 1'b0;
        #1;
        check("t5_async_reset", {tx[0], busy[0], rd_en[0], done[0]}, 4'b1000);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("t5_after_release", {tx[0], busy[0]}, 2'b10);
        push(0, 8'h9A);
        watch(60);
        e = put_frame('1, 2, 8'h9A, 0, 0, 1);
        check("t5_fresh_frame", hist[0], e);
        check("t5_fresh_pop", rd_cnt[0], 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
